mc_ctrl: RTL and testbench

Multicycle MIPS main controller: the initiator side of the datapath control interface, driving ALUOp, mux selects and write enables, and consuming the ALU Zero flag. It decodes Op/Funct latched in the IR and sequences each instruction through a Moore FSM. It sits beside the datapath (PC, IR, RF, ALU, ALUOut, MDR) in the MCCPU top level.

---
 rtl/mc_ctrl_pkg.sv | 96 +++++++++
 rtl/mc_ctrl_alu_dec.sv | 49 ++++
 rtl/mc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_ctrl_pkg                                                          |
// | Shared ALU codes, Op/Funct constants, FSM states and class decode.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mc_ctrl_pkg;

  localparam logic [3:0] c_ALU_NOP  = 4'd0;
  localparam logic [3:0] c_ALU_ADD  = 4'd1;
  localparam logic [3:0] c_ALU_SUB  = 4'd2;
  localparam logic [3:0] c_ALU_AND  = 4'd3;
  localparam logic [3:0] c_ALU_OR   = 4'd4;
  localparam logic [3:0] c_ALU_NOR  = 4'd5;
  localparam logic [3:0] c_ALU_SLT  = 4'd6;
  localparam logic [3:0] c_ALU_SLTU = 4'd7;
  localparam logic [3:0] c_ALU_SLL  = 4'd8;
  localparam logic [3:0] c_ALU_SRL  = 4'd9;
  localparam logic [3:0] c_ALU_LUI  = 4'd10;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_ADDIU = 6'h09;
  localparam logic [5:0] c_OP_SLTI  = 6'h0A;
  localparam logic [5:0] c_OP_ANDI  = 6'h0C;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LUI   = 6'h0F;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  localparam logic [5:0] c_FN_SLL  = 6'h00;
  localparam logic [5:0] c_FN_SRL  = 6'h02;
  localparam logic [5:0] c_FN_SLLV = 6'h04;
  localparam logic [5:0] c_FN_SRLV = 6'h06;
  localparam logic [5:0] c_FN_JR   = 6'h08;
  localparam logic [5:0] c_FN_ADD  = 6'h20;
  localparam logic [5:0] c_FN_ADDU = 6'h21;
  localparam logic [5:0] c_FN_SUB  = 6'h22;
  localparam logic [5:0] c_FN_SUBU = 6'h23;
  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_OR   = 6'h25;
  localparam logic [5:0] c_FN_NOR  = 6'h27;
  localparam logic [5:0] c_FN_SLT  = 6'h2A;
  localparam logic [5:0] c_FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DCODE  = 4'd1,
    S_MADR   = 4'd2,
    S_MRD    = 4'd3,
    S_MWB    = 4'd4,
    S_MWR    = 4'd5,
    S_EXE    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    IC_MEM     = 3'd0,
    IC_RALU    = 3'd1,
    IC_IALU    = 3'd2,
    IC_BRANCH  = 3'd3,
    IC_JUMP    = 3'd4,
    IC_ILLEGAL = 3'd5
  } iclass_e;

  // Picks the DCODE successor; jr is routed with the jumps, not the ALU ops.
  function automatic iclass_e classify(input logic [5:0] op, input logic [5:0] funct);
    iclass_e cls;
    cls = IC_ILLEGAL;
    case (op)
      c_OP_RTYPE: begin
        case (funct)
          c_FN_ADD, c_FN_ADDU, c_FN_SUB, c_FN_SUBU, c_FN_AND, c_FN_OR, c_FN_NOR,
          c_FN_SLT, c_FN_SLTU, c_FN_SLL, c_FN_SRL, c_FN_SLLV, c_FN_SRLV: cls = IC_RALU;
          c_FN_JR: cls = IC_JUMP;
          default: cls = IC_ILLEGAL;
        endcase
      end
      c_OP_LW, c_OP_SW:                       cls = IC_MEM;
      c_OP_BEQ, c_OP_BNE:                     cls = IC_BRANCH;
      c_OP_J, c_OP_JAL:                       cls = IC_JUMP;
      c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI,
      c_OP_ANDI, c_OP_ORI, c_OP_LUI:          cls = IC_IALU;
      default:                                cls = IC_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_alu_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_ctrl_alu_dec                                                      |
// | Combinational Op/Funct -> ALUOp, shamt-source select, EXTOp.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mc_ctrl_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       shamt_sel_o,
  output logic       ext_op_o
);

  always_comb begin
    alu_op_o    = c_ALU_NOP;
    shamt_sel_o = 1'b0;
    ext_op_o    = 1'b0;
    if (op_i == c_OP_RTYPE) begin
      case (funct_i)
        c_FN_ADD, c_FN_ADDU: alu_op_o = c_ALU_ADD;
        c_FN_SUB, c_FN_SUBU: alu_op_o = c_ALU_SUB;
        c_FN_AND:            alu_op_o = c_ALU_AND;
        c_FN_OR:             alu_op_o = c_ALU_OR;
        c_FN_NOR:            alu_op_o = c_ALU_NOR;
        c_FN_SLT:            alu_op_o = c_ALU_SLT;
        c_FN_SLTU:           alu_op_o = c_ALU_SLTU;
        c_FN_SLL: begin alu_op_o = c_ALU_SLL; shamt_sel_o = 1'b1; end
        c_FN_SRL: begin alu_op_o = c_ALU_SRL; shamt_sel_o = 1'b1; end
        c_FN_SLLV:           alu_op_o = c_ALU_SLL;
        c_FN_SRLV:           alu_op_o = c_ALU_SRL;
        default:             alu_op_o = c_ALU_NOP;
      endcase
    end else begin
      case (op_i)
        c_OP_ADDI, c_OP_ADDIU: begin alu_op_o = c_ALU_ADD; ext_op_o = 1'b1; end
        c_OP_SLTI:             begin alu_op_o = c_ALU_SLT; ext_op_o = 1'b1; end
        c_OP_ANDI:             alu_op_o = c_ALU_AND;
        c_OP_ORI:              alu_op_o = c_ALU_OR;
        c_OP_LUI:              alu_op_o = c_ALU_LUI;
        default:               alu_op_o = c_ALU_NOP;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_ctrl                                                              |
// | Multicycle MIPS main controller: Moore FSM driving datapath controls.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IorD,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUOp,
  output logic               EXTOp,
  output logic [1:0]         PCSource,
  output logic [1:0]         RegDst,
  output logic [1:0]         WDSel,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  state_e     state_q, state_d;
  iclass_e    w_iclass;
  logic [3:0] w_alu_op;
  logic       w_shamt_sel, w_ext_op;
  logic       w_pc_write, w_ir_write, w_mem_write, w_reg_write, w_illegal;

  assign w_iclass = classify(Op, Funct);

  mc_ctrl_alu_dec u_alu_dec (
    .op_i        (Op),
    .funct_i     (Funct),
    .alu_op_o    (w_alu_op),
    .shamt_sel_o (w_shamt_sel),
    .ext_op_o    (w_ext_op)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    IorD        = 1'b0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    ALUOp       = c_ALU_NOP;
    EXTOp       = 1'b0;
    PCSource    = 2'd0;
    RegDst      = 2'd0;
    WDSel       = 2'd0;
    case (state_q)
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        ALUSrcB    = 2'd1;
        ALUOp      = c_ALU_ADD;
        state_d    = S_DCODE;
      end
      // Branch target is computed speculatively here so BRANCH can use ALUOut.
      S_DCODE: begin
        ALUSrcB = 2'd3;
        EXTOp   = 1'b1;
        ALUOp   = c_ALU_ADD;
        case (w_iclass)
          IC_MEM:           state_d = S_MADR;
          IC_RALU, IC_IALU: state_d = S_EXE;
          IC_BRANCH:        state_d = S_BRANCH;
          IC_JUMP:          state_d = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MADR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        EXTOp   = 1'b1;
        ALUOp   = c_ALU_ADD;
        state_d = (Op == c_OP_LW) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        IorD    = 1'b1;
        state_d = S_MWB;
      end
      S_MWB: begin
        w_reg_write = 1'b1;
        WDSel       = 2'd1;
        state_d     = S_FETCH;
      end
      S_MWR: begin
        IorD        = 1'b1;
        w_mem_write = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXE: begin
        ALUOp = w_alu_op;
        EXTOp = w_ext_op;
        if (Op == c_OP_RTYPE) begin
          ALUSrcA = w_shamt_sel ? 2'd2 : 2'd1;
          ALUSrcB = 2'd0;
        end else begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd2;
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        RegDst      = (Op == c_OP_RTYPE) ? 2'd1 : 2'd0;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'd1;
        ALUOp      = c_ALU_SUB;
        PCSource   = 2'd1;
        w_pc_write = (Op == c_OP_BEQ) ? Zero : ~Zero;
        state_d    = S_FETCH;
      end
      // PC already holds PC+4 from FETCH, which is the jal link value.
      S_JUMP: begin
        w_pc_write = 1'b1;
        if (Op == c_OP_RTYPE) begin
          PCSource = 2'd3;
        end else begin
          PCSource = 2'd2;
          if (Op == c_OP_JAL) begin
            w_reg_write = 1'b1;
            RegDst      = 2'd2;
            WDSel       = 2'd2;
          end
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign PCWrite  = w_pc_write  & ~rst;
  assign IRWrite  = w_ir_write  & ~rst;
  assign MemWrite = w_mem_write & ~rst;
  assign RegWrite = w_reg_write & ~rst;
  assign Illegal  = w_illegal   & ~rst;
  assign State    = STATE_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_ctrl                                                           |
// | Directed table plus randomized instruction stream vs. a cycle model. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mc_ctrl;

  localparam logic [3:0] A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4,
                         A_NOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7, A_SLL = 4'd8,
                         A_SRL = 4'd9, A_LUI = 4'd10;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_J = 5, K_ILL = 6;

  typedef struct packed {
    logic       pcw, irw, mw, rw, iord;
    logic [1:0] srca, srcb;
    logic [3:0] aluop;
    logic       ext;
    logic [1:0] pcsrc, regdst, wdsel;
    logic       ill;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic [5:0] op, funct;
    logic       zero;
    int         lat, pk;
    outs_t      e, c;
    string      nm;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, Zero = 1'b0;
  logic [5:0] Op = 6'h00, Funct = 6'h00;
  logic PCWrite, IRWrite, MemWrite, RegWrite, IorD, EXTOp, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, PCSource, RegDst, WDSel;
  logic [3:0] ALUOp, State;
  outs_t act;
  int checks = 0, errors = 0;
  vec_t vq[$];
  vec_t t;

  mc_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .EXTOp(EXTOp),
    .PCSource(PCSource), .RegDst(RegDst), .WDSel(WDSel), .Illegal(Illegal), .State(State)
  );

  assign act = {PCWrite, IRWrite, MemWrite, RegWrite, IorD, ALUSrcA, ALUSrcB, ALUOp,
                EXTOp, PCSource, RegDst, WDSel, Illegal, State};

  always #5 clk = ~clk;

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] f);
    case (op)
      6'h00: begin
        if (f == 6'h08) return K_J;
        if (f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B,
                      6'h00, 6'h02, 6'h04, 6'h06}) return K_R;
        return K_ILL;
      end
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04, 6'h05: return K_BR;
      6'h02, 6'h03: return K_J;
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return K_I;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] f);
    if (op == 6'h00) begin
      case (f)
        6'h20, 6'h21: return A_ADD;
        6'h22, 6'h23: return A_SUB;
        6'h24: return A_AND;
        6'h25: return A_OR;
        6'h27: return A_NOR;
        6'h2A: return A_SLT;
        6'h2B: return A_SLTU;
        6'h00, 6'h04: return A_SLL;
        default: return A_SRL;
      endcase
    end
    case (op)
      6'h08, 6'h09: return A_ADD;
      6'h0A: return A_SLT;
      6'h0C: return A_AND;
      6'h0D: return A_OR;
      default: return A_LUI;
    endcase
  endfunction

  function automatic int lat_of(input logic [5:0] op, input logic [5:0] f);
    int k;
    k = kind_of(op, f);
    if (k == K_LW) return 5;
    if (k == K_SW || k == K_R || k == K_I) return 4;
    if (k == K_BR || k == K_J) return 3;
    return 2;
  endfunction

  // Expected outputs (e) and which fields matter (c) in cycle k of one instruction.
  task automatic model(input logic [5:0] op, input logic [5:0] f, input logic z, input int k,
                       output outs_t e, output outs_t c);
    int kd;
    kd = kind_of(op, f);
    e = '0; c = '0;
    c.pcw = 1'b1; c.irw = 1'b1; c.mw = 1'b1; c.rw = 1'b1; c.ill = 1'b1; c.state = '1;
    if (k == 0) begin
      e.state = 4'd0; e.pcw = 1'b1; e.irw = 1'b1; e.srcb = 2'd1; e.aluop = A_ADD;
      c.iord = 1'b1; c.srca = '1; c.srcb = '1; c.aluop = '1; c.pcsrc = '1;
    end else if (k == 1) begin
      e.state = 4'd1; e.srcb = 2'd3; e.ext = 1'b1; e.aluop = A_ADD; e.ill = (kd == K_ILL);
      c.srca = '1; c.srcb = '1; c.ext = 1'b1; c.aluop = '1;
    end else if (kd == K_LW || kd == K_SW) begin
      if (k == 2) begin
        e.state = 4'd2; e.srca = 2'd1; e.srcb = 2'd2; e.ext = 1'b1; e.aluop = A_ADD;
        c.srca = '1; c.srcb = '1; c.ext = 1'b1; c.aluop = '1;
      end else if (k == 3) begin
        e.state = (kd == K_LW) ? 4'd3 : 4'd5; e.iord = 1'b1; e.mw = (kd == K_SW); c.iord = 1'b1;
      end else begin
        e.state = 4'd4; e.rw = 1'b1; e.wdsel = 2'd1; e.regdst = 2'd0;
        c.regdst = '1; c.wdsel = '1;
      end
    end else if (kd == K_R || kd == K_I) begin
      if (k == 2) begin
        e.state = 4'd6; e.aluop = alu_of(op, f); c.aluop = '1; c.srca = '1; c.srcb = '1;
        if (kd == K_R) begin
          e.srca = (f == 6'h00 || f == 6'h02) ? 2'd2 : 2'd1; e.srcb = 2'd0;
        end else begin
          e.srca = 2'd1; e.srcb = 2'd2; c.ext = 1'b1;
          e.ext = (op == 6'h08 || op == 6'h09 || op == 6'h0A);
        end
      end else begin
        e.state = 4'd7; e.rw = 1'b1; e.regdst = (kd == K_R) ? 2'd1 : 2'd0;
        c.regdst = '1; c.wdsel = '1;
      end
    end else if (kd == K_BR) begin
      e.state = 4'd8; e.srca = 2'd1; e.srcb = 2'd0; e.aluop = A_SUB; e.pcsrc = 2'd1;
      e.pcw = (op == 6'h04) ? z : ~z;
      c.srca = '1; c.srcb = '1; c.aluop = '1; c.pcsrc = '1;
    end else begin
      e.state = 4'd9; e.pcw = 1'b1; e.pcsrc = (op == 6'h00) ? 2'd3 : 2'd2; c.pcsrc = '1;
      if (op == 6'h03) begin
        e.rw = 1'b1; e.regdst = 2'd2; e.wdsel = 2'd2; c.regdst = '1; c.wdsel = '1;
      end
    end
  endtask

  task automatic chk(input string nm, input outs_t a, input outs_t e, input outs_t c);
    logic [24:0] d;
    checks++;
    d = (a ^ e) & c;
    if (d != '0) begin
      errors++;
      $display("FAIL %s: got %h want %h (care %h)", nm, a, e, c);
    end
  endtask

  // Entered just after a falling edge with the DUT in FETCH; leaves it the same way.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                           input int n, input string tag, input bit probe, input int pk,
                           input outs_t pe, input outs_t pc);
    outs_t e, c;
    Op = op; Funct = f; Zero = z;
    #1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      model(op, f, z, k, e, c);
      chk($sformatf("%s model cyc%0d", tag, k), act, e, c);
      if (probe && k == pk) chk($sformatf("%s table", tag), act, pe, pc);
    end
    @(negedge clk); #1;
    e = '0; c = '0; c.state = '1;
    chk($sformatf("%s back to FETCH", tag), act, e, c);
  endtask

  task automatic reset_mid(input logic [5:0] op, input logic [5:0] f, input int kstop,
                           input string tag);
    outs_t e, c;
    Op = op; Funct = f; Zero = 1'b0;
    #1;
    for (int k = 0; k < kstop; k++) begin @(negedge clk); #1; end
    model(op, f, 1'b0, kstop, e, c);
    rst = 1'b1;
    #1;
    e.pcw = 1'b0; e.irw = 1'b0; e.mw = 1'b0; e.rw = 1'b0; e.ill = 1'b0;
    c = '0; c.pcw = 1'b1; c.irw = 1'b1; c.mw = 1'b1; c.rw = 1'b1; c.ill = 1'b1; c.state = '1;
    chk({tag, " rst asserted"}, act, e, c);
    @(negedge clk); #1;
    e = '0;
    chk({tag, " rst held"}, act, e, c);
    rst = 1'b0;
    #1;
    model(op, f, 1'b0, 0, e, c);
    chk({tag, " released"}, act, e, c);
  endtask

  function automatic vec_t mkv(input logic [5:0] op, input logic [5:0] f, input logic z,
                               input int lat, input int pk, input string nm);
    vec_t v;
    v.op = op; v.funct = f; v.zero = z; v.lat = lat; v.pk = pk; v.nm = nm;
    v.e = '0; v.c = '0;
    return v;
  endfunction

  logic [5:0] rfn [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B,
                          6'h00, 6'h02, 6'h04, 6'h06, 6'h08};
  logic [5:0] iops [12] = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C,
                           6'h0D, 6'h0F, 6'h02, 6'h03};

  initial begin
    outs_t e, c;
    logic [5:0] op, f;
    logic z;
    int r;

    t = mkv(6'h00, 6'h21, 1'b0, 4, 2, "addu EXE"); t.e.state = 4'd6; t.c.state = '1;
    t.e.aluop = A_ADD; t.c.aluop = '1; vq.push_back(t);
    t = mkv(6'h00, 6'h21, 1'b0, 4, 3, "addu ALUWB"); t.e.state = 4'd7; t.c.state = '1;
    t.e.rw = 1'b1; t.c.rw = 1'b1; t.e.regdst = 2'd1; t.c.regdst = '1; vq.push_back(t);
    t = mkv(6'h23, 6'h00, 1'b0, 5, 4, "lw MWB"); t.e.state = 4'd4; t.c.state = '1;
    t.e.rw = 1'b1; t.c.rw = 1'b1; t.e.wdsel = 2'd1; t.c.wdsel = '1; t.c.regdst = '1;
    t.c.mw = 1'b1; vq.push_back(t);
    t = mkv(6'h2B, 6'h00, 1'b0, 4, 3, "sw MWR"); t.e.state = 4'd5; t.c.state = '1;
    t.e.mw = 1'b1; t.c.mw = 1'b1; t.e.iord = 1'b1; t.c.iord = 1'b1; vq.push_back(t);
    t = mkv(6'h04, 6'h00, 1'b1, 3, 2, "beq taken"); t.e.state = 4'd8; t.c.state = '1;
    t.e.pcw = 1'b1; t.c.pcw = 1'b1; t.e.pcsrc = 2'd1; t.c.pcsrc = '1; vq.push_back(t);
    t = mkv(6'h04, 6'h00, 1'b0, 3, 2, "beq not taken"); t.e.state = 4'd8; t.c.state = '1;
    t.c.pcw = 1'b1; vq.push_back(t);
    t = mkv(6'h05, 6'h00, 1'b1, 3, 2, "bne not taken"); t.e.state = 4'd8; t.c.state = '1;
    t.c.pcw = 1'b1; vq.push_back(t);
    t = mkv(6'h05, 6'h00, 1'b0, 3, 2, "bne taken"); t.e.state = 4'd8; t.c.state = '1;
    t.e.pcw = 1'b1; t.c.pcw = 1'b1; t.e.pcsrc = 2'd1; t.c.pcsrc = '1; vq.push_back(t);
    t = mkv(6'h00, 6'h00, 1'b0, 4, 2, "sll EXE"); t.e.srca = 2'd2; t.c.srca = '1;
    t.e.aluop = A_SLL; t.c.aluop = '1; vq.push_back(t);
    t = mkv(6'h0F, 6'h00, 1'b0, 4, 2, "lui EXE"); t.e.aluop = A_LUI; t.c.aluop = '1;
    t.e.srcb = 2'd2; t.c.srcb = '1; vq.push_back(t);
    t = mkv(6'h03, 6'h00, 1'b0, 3, 2, "jal JUMP"); t.e.state = 4'd9; t.c.state = '1;
    t.e.pcw = 1'b1; t.c.pcw = 1'b1; t.e.pcsrc = 2'd2; t.c.pcsrc = '1; t.e.rw = 1'b1;
    t.c.rw = 1'b1; t.e.regdst = 2'd2; t.c.regdst = '1; t.e.wdsel = 2'd2; t.c.wdsel = '1;
    vq.push_back(t);
    t = mkv(6'h00, 6'h08, 1'b0, 3, 2, "jr JUMP"); t.e.pcsrc = 2'd3; t.c.pcsrc = '1;
    t.c.rw = 1'b1; t.e.pcw = 1'b1; t.c.pcw = 1'b1; vq.push_back(t);
    t = mkv(6'h3F, 6'h00, 1'b0, 2, 1, "illegal op"); t.e.state = 4'd1; t.c.state = '1;
    t.e.ill = 1'b1; t.c.ill = 1'b1; vq.push_back(t);
    t = mkv(6'h00, 6'h3F, 1'b0, 2, 1, "illegal funct"); t.e.ill = 1'b1; t.c.ill = 1'b1;
    t.c.rw = 1'b1; t.c.mw = 1'b1; vq.push_back(t);

    rst = 1'b1; Op = 6'h23; Funct = 6'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      e = '0; c = '0; c.pcw = 1'b1; c.irw = 1'b1; c.mw = 1'b1; c.rw = 1'b1; c.ill = 1'b1;
      c.state = '1;
      chk($sformatf("reset hold %0d", i), act, e, c);
    end
    rst = 1'b0;

    foreach (vq[i])
      run_instr(vq[i].op, vq[i].funct, vq[i].zero, vq[i].lat, vq[i].nm, 1'b1,
                vq[i].pk, vq[i].e, vq[i].c);

    reset_mid(6'h23, 6'h00, 3, "rst in MRD");
    run_instr(6'h23, 6'h00, 1'b0, 5, "lw after rst", 1'b0, -1, '0, '0);
    reset_mid(6'h23, 6'h00, 4, "rst in MWB");
    reset_mid(6'h2B, 6'h00, 3, "rst in MWR");

    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        op = 6'h00; f = rfn[$urandom_range(0, 13)];
      end else if (r < 8) begin
        op = iops[$urandom_range(0, 11)]; f = 6'($urandom);
      end else begin
        op = 6'($urandom); f = 6'($urandom);
      end
      z = 1'($urandom);
      run_instr(op, f, z, lat_of(op, f), $sformatf("rand%0d op%h fn%h z%0d", n, op, f, z),
                1'b0, -1, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
